// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch and IF/ID register.
// Optional FETCH_STATS_EN adds fetch_cnt/bubble_cnt counters.
module fetch_stage #(
    parameter logic [31:0] START = 32'h0040_0000,
    parameter int unsigned BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
`ifdef FETCH_STATS_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    localparam logic [31:0] LAST = START + 32'(BYTES) - 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= START) && (a <= LAST);
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_seq;
    logic        tgt_ok;
    logic        seq_ok;
    logic        pc_load;
    logic [31:0] pc_d;
    logic        fault_load;
    logic [31:0] fault_d;
    logic        slot_fill;
    logic        slot_bubble;

    assign pc_seq      = pc + 32'd4;
    assign tgt_ok      = legal(redirect_target);
    assign seq_ok      = legal(pc_seq);
    assign imem_addr   = pc;
    assign fetch_fault = (state == HALT);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a bad redirect target or a bad sequential PC halts
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    if (!tgt_ok) begin
                        state_nxt = HALT;
                    end
                end else if (!stall && !seq_ok) begin
                    state_nxt = HALT;
                end
            end
            HALT: state_nxt = HALT;
        endcase
    end

    // Datapath controls; redirect outranks stall
    always_comb begin
        pc_load     = 1'b0;
        pc_d        = pc;
        fault_load  = 1'b0;
        fault_d     = fault_pc;
        slot_fill   = 1'b0;
        slot_bubble = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    slot_bubble = 1'b1;
                    if (tgt_ok) begin
                        pc_load = 1'b1;
                        pc_d    = redirect_target;
                    end else begin
                        fault_load = 1'b1;
                        fault_d    = redirect_target;
                    end
                end else if (!stall) begin
                    slot_fill = 1'b1;
                    if (seq_ok) begin
                        pc_load = 1'b1;
                        pc_d    = pc_seq;
                    end else begin
                        fault_load = 1'b1;
                        fault_d    = pc_seq;
                    end
                end
            end
            HALT: slot_bubble = 1'b1;
        endcase
    end

    // Program counter and fault capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= START;
            fault_pc <= 32'd0;
        end else begin
            if (pc_load) begin
                pc <= pc_d;
            end
            if (fault_load) begin
                fault_pc <= fault_d;
            end
        end
    end

    // IF/ID register; a bubble clears valid and instr, keeps pc/pc4
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            if_id_instr <= 32'd0;
        end else if (slot_fill) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc;
            if_id_pc4   <= pc_seq;
            if_id_instr <= imem_instr;
        end else if (slot_bubble) begin
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
        end
    end

`ifdef FETCH_STATS_EN
    // Count valid writes and bubble writes into IF/ID
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else begin
            if (slot_fill) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (slot_bubble) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, boundary sequences and
// randomized run against a reference model of the fetch rules.
module tb_fetch_stage;

    localparam logic [31:0] START = 32'h0040_0000;
    localparam int          BYTES = 1024;
    localparam int          WORDS = BYTES / 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    logic [31:0] mem [WORDS];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_instr;
    logic [31:0] m_fpc;
    logic [31:0] m_fcnt;
    logic [31:0] m_bcnt;

    always #5 clk = ~clk;

    fetch_stage #(.START(START), .BYTES(BYTES)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc4       (if_id_pc4),
        .if_id_instr     (if_id_instr),
`ifdef FETCH_STATS_EN
        .fetch_cnt       (fetch_cnt),
        .bubble_cnt      (bubble_cnt),
`endif
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc)
    );

    function automatic logic [31:0] memw(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(START);
        if (off < 0 || off >= BYTES) return 32'hDEAD_BEEF;
        return mem[int'(off / 4)];
    endfunction

    assign imem_instr = memw(imem_addr);

    function automatic logic in_window(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(START);
        return (a % 4 == 0) && off >= 0 && off < BYTES;
    endfunction

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s,
                              input logic rv, input logic [31:0] t,
                              input logic [31:0] ins);
        if (!r) begin
            m_pc = START; m_halt = 0; m_valid = 0;
            m_ipc = 0; m_instr = 0; m_fpc = 0;
            m_fcnt = 0; m_bcnt = 0;
        end else if (m_halt) begin
            m_valid = 0; m_instr = 0; m_bcnt++;
        end else if (rv) begin
            m_valid = 0; m_instr = 0; m_bcnt++;
            if (in_window(t)) m_pc = t;
            else begin m_halt = 1; m_fpc = t; end
        end else if (!s) begin
            m_valid = 1; m_ipc = m_pc; m_instr = ins; m_fcnt++;
            if (in_window(m_pc + 32'd4)) m_pc = m_pc + 32'd4;
            else begin m_halt = 1; m_fpc = m_pc + 32'd4; end
        end
    endtask

    task automatic cmp_model();
        chk("addr", imem_addr, m_pc);
        chk("valid", 32'(if_id_valid), 32'(m_valid));
        chk("ifpc", if_id_pc, m_ipc);
        chk("ifpc4", if_id_pc4, m_ipc + (m_ipc == 0 && !m_valid &&
            if_id_pc4 == 0 ? 32'd0 : 32'd4));
        chk("instr", if_id_instr, m_instr);
        chk("fault", 32'(fetch_fault), 32'(m_halt));
        chk("fpc", fault_pc, m_fpc);
`ifdef FETCH_STATS_EN
        chk("fcnt", fetch_cnt, m_fcnt);
        chk("bcnt", bubble_cnt, m_bcnt);
`endif
    endtask

    // one clock: drive inputs, step the model, sample 1 time unit later
    task automatic cyc(input logic r, input logic s, input logic rv,
                       input logic [31:0] t, input logic cm);
        logic [31:0] ins;
        rst_n = r; stall = s; redirect_valid = rv; redirect_target = t;
        ins = memw(m_pc);
        @(posedge clk);
        model_step(r, s, rv, t, ins);
        #1;
        if (cm) cmp_model();
    endtask

    typedef struct {
        logic        s;
        logic        rv;
        logic [31:0] t;
        logic [31:0] addr;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] ins;
        logic        f;
        logic [31:0] fpc;
    } vec_t;

    vec_t tab[12];

    initial begin
        logic [31:0] t;
        int          k;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'hC0DE_0000 + i;
        m_pc = START; m_halt = 0;
        rst_n = 0; stall = 0; redirect_valid = 0; redirect_target = 0;

        tab[0]  = '{0, 0, 0, START + 4, 1, START, mem[0], 0, 0};
        tab[1]  = '{0, 0, 0, START + 8, 1, START + 4, mem[1], 0, 0};
        tab[2]  = '{1, 0, 0, START + 8, 1, START + 4, mem[1], 0, 0};
        tab[3]  = '{1, 0, 0, START + 8, 1, START + 4, mem[1], 0, 0};
        tab[4]  = '{1, 0, 0, START + 8, 1, START + 4, mem[1], 0, 0};
        tab[5]  = '{0, 0, 0, START + 12, 1, START + 8, mem[2], 0, 0};
        tab[6]  = '{0, 0, 0, START + 16, 1, START + 12, mem[3], 0, 0};
        tab[7]  = '{1, 1, START + 32, START + 32, 0, START + 12, 0, 0, 0};
        tab[8]  = '{0, 0, 0, START + 36, 1, START + 32, mem[8], 0, 0};
        tab[9]  = '{0, 1, START + 34, START + 36, 0, START + 32, 0, 1,
                    START + 34};
        tab[10] = '{0, 1, START, START + 36, 0, START + 32, 0, 1,
                    START + 34};
        tab[11] = '{1, 0, 0, START + 36, 0, START + 32, 0, 1, START + 34};

        // reset state
        cyc(0, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, START);
        chk("rst_valid", 32'(if_id_valid), 0);
        chk("rst_ifpc", if_id_pc, 0);
        chk("rst_ifpc4", if_id_pc4, 0);
        chk("rst_instr", if_id_instr, 0);
        chk("rst_fault", 32'(fetch_fault), 0);
        chk("rst_fpc", fault_pc, 0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            cyc(1, tab[i].s, tab[i].rv, tab[i].t, 0);
            chk($sformatf("t%0d_addr", i), imem_addr, tab[i].addr);
            chk($sformatf("t%0d_valid", i), 32'(if_id_valid),
                32'(tab[i].v));
            chk($sformatf("t%0d_ifpc", i), if_id_pc, tab[i].ipc);
            chk($sformatf("t%0d_ifpc4", i), if_id_pc4, tab[i].ipc + 4);
            chk($sformatf("t%0d_instr", i), if_id_instr, tab[i].ins);
            chk($sformatf("t%0d_fault", i), 32'(fetch_fault),
                32'(tab[i].f));
            chk($sformatf("t%0d_fpc", i), fault_pc, tab[i].fpc);
        end

        // reset clears the fault
        cyc(0, 0, 0, 0, 0);
        chk("clr_addr", imem_addr, START);
        chk("clr_fault", 32'(fetch_fault), 0);
        chk("clr_fpc", fault_pc, 0);

        // sequential run to the last word of the window
        for (int i = 0; i < WORDS; i++) cyc(1, 0, 0, 0, 1);
        chk("end_valid", 32'(if_id_valid), 1);
        chk("end_ifpc", if_id_pc, START + BYTES - 4);
        chk("end_instr", if_id_instr, mem[WORDS - 1]);
        chk("end_fault", 32'(fetch_fault), 1);
        chk("end_fpc", fault_pc, START + BYTES);
        cyc(1, 0, 0, 0, 1);
        chk("end_bubble", 32'(if_id_valid), 0);

`ifdef FETCH_STATS_EN
        // 5 fetches, 1 redirect, 2 stalls
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        cyc(1, 0, 1, START + 64, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        chk("stat_fetch", fetch_cnt, 32'd5);
        chk("stat_bubble", bubble_cnt, 32'd1);
`endif

        // randomized run against the model
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            k = int'($urandom_range(0, 99));
            case ($urandom_range(0, 9))
                0: t = START + 4 * $urandom_range(0, WORDS - 1) + 2;
                1: t = (k < 50) ? START + BYTES : START - 4;
                2: t = START + BYTES - 4 * $urandom_range(1, 3);
                default: t = START + 4 * $urandom_range(0, WORDS - 1);
            endcase
            cyc(k >= 2, $urandom_range(0, 9) < 3,
                $urandom_range(0, 99) < 8, t, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
